mux_op_sequencer: RTL and testbench

- Upstream driver and result collector for the 8-bit opcode-selected mux/operation stage.
- On `start`, it latches an 8-bit operand and drives it on `mux_in`.
- It then steps `mux_op` through all eight opcodes, 0 to 7, holding each for a programmable dwell time.
- At the end of each dwell it samples the stage's output and folds it into a running 8-bit signature. Sweeps run automatically, with no per-opcode bench stepping.

---
 rtl/mux_op_sequencer_if.sv | 32 +++
 rtl/mux_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_mux_op_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_op_sequencer_if.sv
// Handshake bundle between the sweep sequencer and its driver/collector.
// The slave side is the sequencer; the master side starts sweeps and returns res.
interface mux_op_sequencer_if #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int DWELL_W = 4
);
    logic               start;
    logic               abort;
    logic [DATA_W-1:0]  operand;
    logic [DWELL_W-1:0] dwell;
    logic [DATA_W-1:0]  mux_in;
    logic [OP_W-1:0]    mux_op;
    logic [DATA_W-1:0]  res;
    logic               sample_valid;
    logic [DATA_W-1:0]  sample_data;
    logic [DATA_W-1:0]  signature;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, operand, dwell, res,
        input  mux_in, mux_op, sample_valid, sample_data,
        input  signature, busy, done
    );

    modport slave (
        input  start, abort, operand, dwell, res,
        output mux_in, mux_op, sample_valid, sample_data,
        output signature, busy, done
    );
endinterface

// File: rtl/mux_op_sequencer.sv
// Sweeps mux_op 0..7 over a latched operand and folds each result into a signature.
// Define SEQ_LFSR_EN to source mux_in from an internal LFSR instead of operand.
module mux_op_sequencer #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int DWELL_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux_op_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [OP_W-1:0] OP_LAST = '1;

    logic [1:0]         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic [DATA_W-1:0]  in_q, in_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  sdata_q, sdata_d;
    logic               svalid_q, svalid_d;
    logic [DATA_W-1:0]  sig_q, sig_d;

    logic [DWELL_W-1:0] dwell_m1;
    logic [DATA_W-1:0]  load_val;
    logic               accept;

    // dwell 0 behaves as dwell 1, so the reload value saturates at 0
    assign dwell_m1 = (bus.dwell == '0) ? '0
                    : bus.dwell - DWELL_W'(1);

    assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;

`ifdef SEQ_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign load_val = DATA_W'(lfsr_q);

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept)
            lfsr_d = {lfsr_q[6:0],
                      lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= 8'h01;
        else
            lfsr_q <= lfsr_d;
    end
`else
    assign load_val = bus.operand;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        in_d     = in_q;
        op_d     = op_q;
        sdata_d  = sdata_q;
        svalid_d = 1'b0;
        sig_d    = sig_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    in_d     = load_val;
                    op_d     = '0;
                    sig_d    = '0;
                    reload_d = dwell_m1;
                    cnt_d    = dwell_m1;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (bus.abort) begin
                    op_d    = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            S_SAMPLE: begin
                if (bus.abort) begin
                    op_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    sdata_d  = bus.res;
                    svalid_d = 1'b1;
                    sig_d    = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]}
                             ^ bus.res;
                    if (op_q == OP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        op_d    = op_q + OP_W'(1);
                        cnt_d   = reload_q;
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            in_q     <= '0;
            op_q     <= '0;
            sdata_q  <= '0;
            svalid_q <= 1'b0;
            sig_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            in_q     <= in_d;
            op_q     <= op_d;
            sdata_q  <= sdata_d;
            svalid_q <= svalid_d;
            sig_q    <= sig_d;
        end
    end

    assign bus.mux_in       = in_q;
    assign bus.mux_op       = op_q;
    assign bus.sample_data  = sdata_q;
    assign bus.sample_valid = svalid_q;
    assign bus.signature    = sig_q;
    assign bus.busy         = (state_q == S_DRIVE) ||
                              (state_q == S_SAMPLE);
    assign bus.done         = (state_q == S_DONE);
endmodule

// File: tb/tb_mux_op_sequencer.sv
// Bench for mux_op_sequencer: vector table of sweeps plus abort/reset sequences.
// Expected samples are queued at start and popped on each sample_valid.
module tb_mux_op_sequencer;
    logic clk;
    logic rst_n;

    mux_op_sequencer_if #(.DATA_W(8), .OP_W(3), .DWELL_W(4)) bus ();

    mux_op_sequencer #(.DATA_W(8), .OP_W(3), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] operand;
        logic [3:0] dwell;
        int         mode;
        bit         use_const;
        logic [7:0] exp_sig;
        bit         mid_start;
    } vec_t;

    int n_vec;
    int n_err;
    int n_pop;
    int cur_mode;
    logic [7:0] cur_in;
    logic [7:0] last_in;
    logic [7:0] lfsr_m;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] res_fn(input logic [2:0] op,
                                          input int mode,
                                          input logic [7:0] base);
        logic [7:0] r;
        case (mode)
            0:       r = {5'b0, op};
            1:       r = 8'hFF;
            default: r = base ^ {op, op, op[1:0]};
        endcase
        return r;
    endfunction

    always_comb bus.res = res_fn(bus.mux_op, cur_mode, cur_in);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sample_extra: got %0h expected none",
                         bus.sample_data);
            end else begin
                chk("sample_data", bus.sample_data, exp_q.pop_front());
                n_pop++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic next_in(input logic [7:0] op_in, output logic [7:0] e);
`ifdef SEQ_LFSR_EN
        e = lfsr_m;
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
        e = op_in;
`endif
    endtask

    task automatic start_sweep(input logic [7:0] op_in, input logic [3:0] dw,
                               input int mode);
        logic [7:0] e;
        next_in(op_in, e);
        cur_in = e;
        last_in = e;
        cur_mode = mode;
        for (int op = 0; op < 8; op++)
            exp_q.push_back(res_fn(3'(op), mode, e));
        @(negedge clk);
        bus.start = 1'b1;
        bus.operand = op_in;
        bus.dwell = dw;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.operand = ~op_in;
        bus.dwell = dw + 4'd5;
        chk("busy_rise", bus.busy, 1);
        chk("mux_in", bus.mux_in, e);
        chk("mux_op_first", bus.mux_op, 0);
    endtask

    task automatic run_sweep(input vec_t v);
        logic [7:0] es;
        int d, cnt, pop0;
        bit seen;
        d = (v.dwell == 0) ? 1 : int'(v.dwell);
        pop0 = n_pop;
        start_sweep(v.operand, v.dwell, v.mode);
        es = 8'h00;
        for (int op = 0; op < 8; op++)
            es = {es[6:0], es[7]} ^ res_fn(3'(op), v.mode, cur_in);
        if (v.use_const) es = v.exp_sig;
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            bus.start = v.mid_start && (k == 5);
            if (bus.done) begin
                seen = 1;
                break;
            end
            chk("mux_op_step", bus.mux_op, k / (d + 1));
            chk("mux_in_hold", bus.mux_in, cur_in);
            cnt++;
        end
        bus.start = 1'b0;
        chk("done_seen", seen, 1);
        chk("sweep_len", cnt, 8 * (d + 1));
        chk("signature", bus.signature, es);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
        chk("sample_count", n_pop - pop0, 8);
        chk("mux_op_hold7", bus.mux_op, 7);
    endtask

    initial begin
        vec_t tbl[6];
        logic [7:0] e;
        bit seen;
        tbl[0] = '{8'hA5, 4'd3,  2, 0, 8'h00, 0};
        tbl[1] = '{8'hFF, 4'd1,  0, 1, 8'h0F, 1};
        tbl[2] = '{8'hFF, 4'd1,  1, 1, 8'h00, 0};
        tbl[3] = '{8'h3C, 4'd0,  0, 1, 8'h0F, 0};
        tbl[4] = '{8'h5A, 4'd15, 2, 0, 8'h00, 0};
        tbl[5] = '{8'h00, 4'd2,  1, 1, 8'h00, 0};

        n_vec = 0;
        n_err = 0;
        n_pop = 0;
        cur_mode = 0;
        cur_in = 8'h00;
        last_in = 8'h00;
        lfsr_m = 8'h01;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.operand = 8'h00;
        bus.dwell = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_mux_in", bus.mux_in, 0);
        chk("rst_mux_op", bus.mux_op, 0);
        chk("rst_sig", bus.signature, 0);
        chk("rst_sdata", bus.sample_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_sweep(tbl[i]);

        // start and abort together in IDLE must not launch a sweep
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_sa_busy", bus.busy, 0);
        chk("idle_sa_op", bus.mux_op, 7);
        chk("idle_sa_in", bus.mux_in, last_in);
        @(negedge clk);
        chk("idle_sa_done", bus.done, 0);

        // abort while opcode 4 is driven
        start_sweep(8'h77, 4'd1, 0);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.mux_op == 3'd4) begin
                seen = 1;
                break;
            end
        end
        chk("abort_reach4", seen, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_op", bus.mux_op, 0);
        chk("abort_sig", bus.signature, 8'h03);
        chk("abort_sdata", bus.sample_data, 8'h03);
        chk("abort_left", exp_q.size(), 4);
        exp_q.delete();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.sample_valid) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_sig_hold", bus.signature, 8'h03);

        // asynchronous reset while opcode 3 is driven
        start_sweep(8'hC3, 4'd2, 2);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.mux_op == 3'd3) begin
                seen = 1;
                break;
            end
        end
        chk("rst_reach3", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_mux_in", bus.mux_in, 0);
        chk("arst_mux_op", bus.mux_op, 0);
        chk("arst_sig", bus.signature, 0);
        chk("arst_sdata", bus.sample_data, 0);
        chk("arst_valid", bus.sample_valid, 0);
        chk("arst_done", bus.done, 0);
        exp_q.delete();
        lfsr_m = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(tbl[0]);
        next_in(8'h00, e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
